// File: rtl/zone_alarm_ctrl.sv
// zone_alarm_ctrl: door-zone vehicle alarm with arming sequence and delay timer; ZONE_ALARM_LOG_EN enables the alarm entry counter
module zone_alarm_ctrl #(
  parameter int N_DOORS = 4,
  parameter int TW = 4,
  parameter int CLK_DIV = 100_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ignition,
  input  logic [N_DOORS-1:0] door,
  input  logic [TW-1:0]      t_arm,
  input  logic [TW-1:0]      t_driver,
  input  logic [TW-1:0]      t_pass,
  input  logic [TW-1:0]      t_siren,
  output logic               status,
  output logic               siren_en,
  output logic [2:0]         state,
  output logic [N_DOORS-1:0] trig_zone,
  output logic [TW-1:0]      remaining,
  output logic [7:0]         alarm_count
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(CLK_DIV - 1);
  typedef enum logic [2:0] {ARMED = 3'd0, DISARMED = 3'd1, TRIGGER = 3'd2, ALARM = 3'd3, SILENCE = 3'd4} main_t;
  typedef enum logic [1:0] {WAIT_IGN_OFF, WAIT_DRV_OPEN, WAIT_CLOSE, ARM_DELAY} arm_t;
  main_t st, st_n;
  arm_t arm, arm_n;
  logic [PW-1:0] presc;
  logic [TW-1:0] timer, load_val;
  logic tick, expired, load, blink, any_door;
  assign any_door = |door;
  assign tick = presc == P_MAX;
  assign expired = tick && timer == TW'(1);
  assign status = st == ARMED ? blink : st != DISARMED;
  assign state = st;
  assign remaining = timer;
  // main FSM next state and timer load; ignition overrides everything, a load wins over a pending tick
  always_comb begin
    st_n = st;
    load = 1'b0;
    load_val = t_siren;
    if (ignition) st_n = DISARMED;
    else case (st)
      ARMED: if (any_door) begin
        st_n = TRIGGER;
        load = 1'b1;
        load_val = door[0] ? t_driver : t_pass;
      end
      TRIGGER: if (expired) begin
        st_n = ALARM;
        load = 1'b1;
      end
      ALARM: if (!any_door) begin
        st_n = SILENCE;
        load = 1'b1;
      end
      SILENCE: st_n = any_door ? ALARM : expired ? ARMED : SILENCE;
      DISARMED: begin
        if (arm == WAIT_CLOSE && !any_door) begin
          load = 1'b1;
          load_val = t_arm;
        end
        if (arm == ARM_DELAY && !any_door && expired) st_n = ARMED;
      end
      default: st_n = ARMED;
    endcase
  end
  // arming sub-FSM only advances while staying in DISARMED with ignition off
  always_comb begin
    arm_n = (ignition || st_n != DISARMED) ? WAIT_IGN_OFF
      : arm == WAIT_IGN_OFF ? WAIT_DRV_OPEN
      : arm == WAIT_DRV_OPEN ? (door[0] ? WAIT_CLOSE : WAIT_DRV_OPEN)
      : any_door ? WAIT_CLOSE : ARM_DELAY;
  end
  // state registers, registered siren and trigger zone capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st <= ARMED;
      arm <= WAIT_IGN_OFF;
      siren_en <= 1'b0;
      trig_zone <= '0;
    end else begin
      st <= st_n;
      arm <= arm_n;
      siren_en <= st_n == ALARM || st_n == SILENCE;
      if (st_n == DISARMED) trig_zone <= '0;
      else if (st == ARMED && st_n == TRIGGER) trig_zone <= door;
    end
  end
  // 1 s prescaler restarted by each load, blink phase and seconds timer (zero loads as one)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= '0;
      timer <= '0;
      blink <= 1'b0;
    end else begin
      blink <= blink ^ tick;
      presc <= (load || tick) ? '0 : presc + 1'b1;
      if (load) timer <= load_val == '0 ? TW'(1) : load_val;
      else if (tick && timer != '0) timer <= timer - 1'b1;
    end
  end
`ifdef ZONE_ALARM_LOG_EN
  logic [7:0] cnt;
  // saturating count of TRIGGER to ALARM entries
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt <= 8'd0;
    else if (st == TRIGGER && st_n == ALARM && cnt != 8'hFF) cnt <= cnt + 8'd1;
  end
  assign alarm_count = cnt;
`else
  assign alarm_count = 8'd0;
`endif
endmodule

// File: tb/tb_zone_alarm_ctrl.sv
// tb_zone_alarm_ctrl: table-driven directed checks of zone_alarm_ctrl with CLK_DIV=4, N_DOORS=4, TW=4
module tb_zone_alarm_ctrl;
  localparam int S_ARMED = 0, S_DIS = 1, S_TRIG = 2, S_ALARM = 3, S_SIL = 4;
`ifdef ZONE_ALARM_LOG_EN
  localparam int LOG = 1;
`else
  localparam int LOG = 0;
`endif
  logic clock = 1'b0, reset = 1'b1, ignition = 1'b0;
  logic [3:0] door = 4'b0, t_arm = 4'd2, t_driver = 4'd0, t_pass = 4'd3, t_siren = 4'd2;
  logic status, siren_en;
  logic [2:0] state;
  logic [3:0] trig_zone, remaining;
  logic [7:0] alarm_count;
  int total = 0, passed = 0, entries;
  typedef struct {
    string name;
    bit ign;
    logic [3:0] door;
    int steps;
    int st;
    bit siren;
    logic [3:0] tz;
    logic [3:0] rem;
    int cnt;
  } vec_t;
  vec_t tbl [26];
  zone_alarm_ctrl #(.N_DOORS(4), .TW(4), .CLK_DIV(4)) dut (
    .clock(clock), .reset(reset), .ignition(ignition), .door(door),
    .t_arm(t_arm), .t_driver(t_driver), .t_pass(t_pass), .t_siren(t_siren),
    .status(status), .siren_en(siren_en), .state(state), .trig_zone(trig_zone),
    .remaining(remaining), .alarm_count(alarm_count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask
  initial begin
    step(2);
    chk("rst.state", state, S_ARMED);
    chk("rst.remaining", remaining, 0);
    chk("rst.siren", siren_en, 0);
    chk("rst.status", status, 0);
    chk("rst.trig_zone", trig_zone, 0);
    chk("rst.alarm_count", alarm_count, 0);
    reset = 1'b0;
    step(3); chk("blink3", status, 0);
    step(1); chk("blink4", status, 1);
    step(3); chk("blink7", status, 1);
    step(1); chk("blink8", status, 0);
    tbl[0]  = '{"trigger",       1'b0, 4'b0010, 1,  S_TRIG,  1'b0, 4'b0010, 4'd3, 0};
    tbl[1]  = '{"trig_wait",     1'b0, 4'b0010, 11, S_TRIG,  1'b0, 4'b0010, 4'd1, 0};
    tbl[2]  = '{"alarm",         1'b0, 4'b0010, 1,  S_ALARM, 1'b1, 4'b0010, 4'd2, 1};
    tbl[3]  = '{"alarm_hold",    1'b0, 4'b0010, 3,  S_ALARM, 1'b1, 4'b0010, 4'd2, 1};
    tbl[4]  = '{"silence",       1'b0, 4'b0000, 1,  S_SIL,   1'b1, 4'b0010, 4'd2, 1};
    tbl[5]  = '{"silence_wait",  1'b0, 4'b0000, 7,  S_SIL,   1'b1, 4'b0010, 4'd1, 1};
    tbl[6]  = '{"realarm",       1'b0, 4'b1000, 1,  S_ALARM, 1'b1, 4'b0010, 4'd0, 1};
    tbl[7]  = '{"silence2",      1'b0, 4'b0000, 1,  S_SIL,   1'b1, 4'b0010, 4'd2, 1};
    tbl[8]  = '{"silence2_wait", 1'b0, 4'b0000, 7,  S_SIL,   1'b1, 4'b0010, 4'd1, 1};
    tbl[9]  = '{"rearmed",       1'b0, 4'b0000, 1,  S_ARMED, 1'b0, 4'b0010, 4'd0, 1};
    tbl[10] = '{"idle_armed",    1'b0, 4'b0000, 5,  S_ARMED, 1'b0, 4'b0010, 4'd0, 1};
    tbl[11] = '{"trigger2",      1'b0, 4'b0100, 1,  S_TRIG,  1'b0, 4'b0100, 4'd3, 1};
    tbl[12] = '{"trig2_wait",    1'b0, 4'b0000, 11, S_TRIG,  1'b0, 4'b0100, 4'd1, 1};
    tbl[13] = '{"ign_expiry",    1'b1, 4'b0000, 1,  S_DIS,   1'b0, 4'b0000, 4'd0, 1};
    tbl[14] = '{"ign_hold",      1'b1, 4'b0001, 2,  S_DIS,   1'b0, 4'b0000, 4'd0, 1};
    tbl[15] = '{"ign_off",       1'b0, 4'b0001, 1,  S_DIS,   1'b0, 4'b0000, 4'd0, 1};
    tbl[16] = '{"drv_open",      1'b0, 4'b0001, 1,  S_DIS,   1'b0, 4'b0000, 4'd0, 1};
    tbl[17] = '{"drv_close",     1'b0, 4'b0000, 1,  S_DIS,   1'b0, 4'b0000, 4'd2, 1};
    tbl[18] = '{"delay_wait",    1'b0, 4'b0000, 2,  S_DIS,   1'b0, 4'b0000, 4'd2, 1};
    tbl[19] = '{"door_pulse",    1'b0, 4'b0010, 1,  S_DIS,   1'b0, 4'b0000, 4'd2, 1};
    tbl[20] = '{"reclose",       1'b0, 4'b0000, 1,  S_DIS,   1'b0, 4'b0000, 4'd2, 1};
    tbl[21] = '{"arm_wait",      1'b0, 4'b0000, 7,  S_DIS,   1'b0, 4'b0000, 4'd1, 1};
    tbl[22] = '{"armed",         1'b0, 4'b0000, 1,  S_ARMED, 1'b0, 4'b0000, 4'd0, 1};
    tbl[23] = '{"trig_drv",      1'b0, 4'b0001, 1,  S_TRIG,  1'b0, 4'b0001, 4'd1, 1};
    tbl[24] = '{"trig_drv_wait", 1'b0, 4'b0001, 3,  S_TRIG,  1'b0, 4'b0001, 4'd1, 1};
    tbl[25] = '{"alarm_drv",     1'b0, 4'b0001, 1,  S_ALARM, 1'b1, 4'b0001, 4'd2, 2};
    for (int i = 0; i < 26; i++) begin
      ignition = tbl[i].ign;
      door = tbl[i].door;
      step(tbl[i].steps);
      chk($sformatf("%s.state", tbl[i].name), state, tbl[i].st);
      chk($sformatf("%s.siren", tbl[i].name), siren_en, tbl[i].siren);
      chk($sformatf("%s.trig_zone", tbl[i].name), trig_zone, tbl[i].tz);
      chk($sformatf("%s.remaining", tbl[i].name), remaining, tbl[i].rem);
      chk($sformatf("%s.alarm_count", tbl[i].name), alarm_count, LOG * tbl[i].cnt);
      if (tbl[i].st != S_ARMED) chk($sformatf("%s.status", tbl[i].name), status, tbl[i].st != S_DIS);
    end
    entries = 2;
    while (entries < 256) begin
      door = 4'b0000;
      step(9);
      door = 4'b0001;
      step(5);
      entries++;
      if (entries == 255) chk("count255", alarm_count, LOG * 255);
    end
    chk("sat.state", state, S_ALARM);
    chk("sat.alarm_count", alarm_count, LOG * 255);
    ignition = 1'b1;
    step(1);
    chk("abort.disarmed", state, S_DIS);
    ignition = 1'b0;
    step(2);
    door = 4'b0000;
    step(1);
    chk("abort.loaded", remaining, 2);
    step(3);
    #2 reset = 1'b1;
    #1;
    chk("abort.state", state, S_ARMED);
    chk("abort.remaining", remaining, 0);
    chk("abort.siren", siren_en, 0);
    chk("abort.status", status, 0);
    chk("abort.alarm_count", alarm_count, 0);
    step(1);
    reset = 1'b0;
    step(20);
    chk("post.state", state, S_ARMED);
    chk("post.remaining", remaining, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/zone_alarm_ctrl.md
ZONE_ALARM_CTRL -- requirements
Module: zone_alarm_ctrl

Interface
REQ-001 SHALL have parameter N_DOORS, default 4, the number of door inputs (2..8); door[0] is the driver door and all other doors are passenger doors.
REQ-002 SHALL have parameter TW, default 4, the width of the time-value inputs and of the timer, in bits.
REQ-003 SHALL have parameter CLK_DIV, default 100_000_000, the number of clock cycles per 1-second tick.
REQ-004 SHALL have port clock  input  1  system clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ignition  input  1  ignition on, already debounced.
REQ-007 SHALL have port door  input  N_DOORS  door open, one bit per door, already debounced.
REQ-008 SHALL have ports t_arm, t_driver, t_pass, t_siren  input  TW each  delays in seconds; each value is sampled only when its timer load occurs.
REQ-009 SHALL have port status  output  1  status LED.
REQ-010 SHALL have port siren_en  output  1  siren enable.
REQ-011 SHALL have port state  output  3  main FSM state code.
REQ-012 SHALL have port trig_zone  output  N_DOORS  latched door vector captured at trigger.
REQ-013 SHALL have port remaining  output  TW  current timer count.
REQ-014 SHALL have port alarm_count  output  8  number of ALARM entries.

Function
REQ-015 SHALL implement main FSM states ARMED=0, DISARMED=1, TRIGGER=2, ALARM=3, SILENCE=4.
REQ-016 SHALL, when ignition=1, go to DISARMED on the next edge from any state, overriding every other condition, including expiry.
REQ-017 SHALL, in ARMED, go to TRIGGER when any door bit is 1; on that edge trig_zone <= door; timer loads t_driver if door[0]=1, otherwise t_pass.
REQ-018 SHALL, in TRIGGER, go to ALARM on expired and load t_siren.
REQ-019 SHALL, in ALARM, go to SILENCE when door is all zero and load t_siren.
REQ-020 SHALL, in SILENCE, go to ALARM when any door is 1; otherwise go to ARMED on expired. When a door opens in the same cycle as expired, the FSM goes to ALARM.
REQ-021 SHALL implement an arming sub-FSM that is active only in DISARMED, with states WAIT_IGN_OFF, WAIT_DRV_OPEN, WAIT_CLOSE and ARM_DELAY.
REQ-022 SHALL, in the arming sub-FSM, go WAIT_IGN_OFF->WAIT_DRV_OPEN when ignition=0, and WAIT_DRV_OPEN->WAIT_CLOSE when door[0]=1.
REQ-023 SHALL, in the arming sub-FSM, go WAIT_CLOSE->ARM_DELAY when door is all zero, loading t_arm on that edge.
REQ-024 SHALL, in the arming sub-FSM, go ARM_DELAY->WAIT_CLOSE when any door is 1; on expired in ARM_DELAY the main FSM goes to ARMED.
REQ-025 SHALL send the arming sub-FSM to WAIT_IGN_OFF from any state when ignition=1, and hold it in WAIT_IGN_OFF whenever the main state is not DISARMED.
REQ-026 SHALL implement a prescaler counting 0..CLK_DIV-1 that pulses tick for 1 cycle at CLK_DIV-1.
REQ-027 SHALL clear the prescaler on every timer load, so the first tick occurs exactly CLK_DIV cycles after the load.
REQ-028 SHALL implement a timer that, on load, takes the input value, with 0 treated as 1.
REQ-029 SHALL decrement the timer on each tick while it is nonzero; on the tick where it goes 1->0, expired pulses for 1 cycle.
REQ-030 SHALL produce no expired pulse while the timer count is 0.
REQ-031 SHALL, when a timer load occurs while the timer is running, restart the timer with the new value, and SHALL NOT emit an expired pulse for the interrupted count.
REQ-032 SHALL, in ARMED, drive status = blink, where blink toggles on every tick (a 2 s period); status SHALL be 1 in TRIGGER, ALARM and SILENCE, and 0 in DISARMED.
REQ-033 SHALL drive siren_en = 1 in ALARM or SILENCE, registered so it is valid in the cycle the state is entered.
REQ-034 SHALL increment alarm_count (per REQ-040) on each TRIGGER->ALARM edge, saturating at 255.
REQ-035 SHALL, on entry to DISARMED, clear trig_zone to 0.

Reset
REQ-036 SHALL, on reset, set state to ARMED, the arming sub-FSM to WAIT_IGN_OFF, and the timer, prescaler, blink, trig_zone and alarm_count to 0.
REQ-037 SHALL, on reset, drive status=0 and siren_en=0.
REQ-038 SHALL, when reset is asserted mid-operation, abort any running timer with no expired pulse.

Configuration
REQ-039 SHALL use macro ZONE_ALARM_LOG_EN to control the alarm counter.
REQ-040 SHALL, when ZONE_ALARM_LOG_EN is defined, implement alarm_count per REQ-034.
REQ-041 SHALL, when ZONE_ALARM_LOG_EN is undefined, tie alarm_count to 8'd0 and implement no counter register.

Verification (CLK_DIV=4, N_DOORS=4, TW=4)
REQ-042 SHALL cover: reset, then door=4'b0010, t_pass=3 -> TRIGGER next edge, trig_zone=0010, ALARM exactly 12 cycles after load, siren_en=1, alarm_count=1.
REQ-043 SHALL cover: in ALARM, doors closed, t_siren=2 -> SILENCE; door[3]=1 in the cycle expired pulses -> ALARM; then doors closed for 8 cycles -> ARMED with siren_en=0.
REQ-044 SHALL cover: ignition=1 in TRIGGER in the same cycle as expired -> DISARMED with siren_en=0 and trig_zone=0.
REQ-045 SHALL cover the arming sequence: ignition 1->0, door[0] 1->0, t_arm=2, door[1] pulsed once in ARM_DELAY -> return to WAIT_CLOSE, then ARMED 8 cycles after the last close.
REQ-046 SHALL cover: t_driver=0, door[0]=1 in ARMED -> ALARM 4 cycles after load; 256 alarm cycles -> alarm_count=255; macro undefined -> alarm_count=0.
REQ-047 SHALL cover: reset asserted mid-ARM_DELAY -> state=ARMED and remaining=0 asynchronously, with no expired pulse afterward.
